// File: rtl/mul_result_collector.sv
// Collects registered multiplier results with their flags into a small FIFO for a downstream consumer.
// Optional feature: define COLLECT_STICKY_FLAGS_EN to accumulate the flags of accepted results in sticky_flags.
module mul_result_collector #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       srst,
  input  logic                       mul_enable,
  input  logic                       mul_exc,
  input  logic                       mul_ovf,
  input  logic                       mul_unf,
  input  logic                       mul_valid,
  input  logic [DATA_W-1:0]          mul_result,
  output logic                       issue_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [2:0]                 out_flags,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       drop_err,
  output logic [31:0]                result_cnt,
  output logic [2:0]                 sticky_flags,
  input  logic                       clr_sticky
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [DATA_W+2:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [2:0]        flag_q, flag_d;
  logic              drop_q, drop_d;
  logic [31:0]       rcnt_q, rcnt_d;
  logic              push, pop;

  always_comb begin
    pop      = (count_q != '0) && out_ready;
    push     = mul_valid && ((count_q != FULL) || pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    drop_d   = drop_q;
    rcnt_d   = rcnt_q;
    // Flags are sampled with the enable so they line up with the result one cycle later.
    flag_d   = mul_enable ? {mul_exc, mul_ovf, mul_unf} : flag_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      rcnt_d   = rcnt_q + 32'd1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop) count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
    if (mul_valid && !push) drop_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      flag_q   <= '0;
      drop_q   <= 1'b0;
      rcnt_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      flag_q   <= flag_d;
      drop_q   <= drop_d;
      rcnt_q   <= rcnt_d;
    end
  end

  // Storage holds data only; it is never reset and is qualified by out_valid.
  always_ff @(posedge clk) begin
    if (push && !srst) mem_q[wr_ptr_q] <= {flag_q, mul_result};
  end

`ifdef COLLECT_STICKY_FLAGS_EN
  logic [2:0] sticky_q, sticky_d;
  logic [2:0] push_flags;

  always_comb begin
    push_flags = push ? flag_q : 3'b000;
    // A push in the clearing cycle still records its own flags.
    sticky_d   = clr_sticky ? push_flags : (sticky_q | push_flags);
  end

  always_ff @(posedge clk) begin
    if (srst) sticky_q <= '0;
    else      sticky_q <= sticky_d;
  end

  assign sticky_flags = sticky_q;
`else
  logic unused_clr_sticky;
  assign unused_clr_sticky = clr_sticky;
  assign sticky_flags      = 3'b000;
`endif

  // Conservative: a same-cycle pop is not credited.
  assign issue_ready = ({1'b0, count_q} + (CW+1)'(mul_valid)) < (CW+1)'(DEPTH);
  assign out_valid   = (count_q != '0);
  assign out_data    = mem_q[rd_ptr_q][DATA_W-1:0];
  assign out_flags   = mem_q[rd_ptr_q][DATA_W+2:DATA_W];
  assign count       = count_q;
  assign drop_err    = drop_q;
  assign result_cnt  = rcnt_q;
endmodule

// File: tb/tb_mul_result_collector.sv
// Randomized and directed bench for mul_result_collector against a queue-based reference model.
module tb_mul_result_collector;
  localparam int DATA_W = 64;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              srst, mul_enable, mul_exc, mul_ovf, mul_unf, mul_valid;
  logic [DATA_W-1:0] mul_result, out_data;
  logic              issue_ready, out_valid, out_ready, drop_err, clr_sticky;
  logic [2:0]        out_flags, sticky_flags;
  logic [$clog2(DEPTH):0] count;
  logic [31:0]       result_cnt;

  int checks = 0;
  int failures = 0;

  // Reference state
  logic [DATA_W+2:0] mq[$];
  logic [2:0]        m_flag;
  logic              m_drop;
  logic [31:0]       m_rcnt;
  logic [2:0]        m_sticky;

  mul_result_collector #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .srst(srst), .mul_enable(mul_enable), .mul_exc(mul_exc), .mul_ovf(mul_ovf),
    .mul_unf(mul_unf), .mul_valid(mul_valid), .mul_result(mul_result), .issue_ready(issue_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_flags(out_flags),
    .count(count), .drop_err(drop_err), .result_cnt(result_cnt), .sticky_flags(sticky_flags),
    .clr_sticky(clr_sticky)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    srst = 0; mul_enable = 0; mul_exc = 0; mul_ovf = 0; mul_unf = 0;
    mul_valid = 0; mul_result = '0; out_ready = 0; clr_sticky = 0;
  endtask

  task automatic model_reset();
    mq.delete(); m_flag = 0; m_drop = 0; m_rcnt = 0; m_sticky = 0;
  endtask

  // Check outputs against the model mid-cycle, then advance the model across the edge.
  task automatic step();
    logic pop, acc;
    logic [2:0] pf;
    @(negedge clk);
    check("count", count, mq.size());
    check("out_valid", out_valid, mq.size() != 0);
    check("issue_ready", issue_ready, (mq.size() + int'(mul_valid)) < DEPTH);
    check("drop_err", drop_err, m_drop);
    check("result_cnt", result_cnt, m_rcnt);
    check("sticky", sticky_flags, m_sticky);
    if (mq.size() != 0) begin
      check("out_data", out_data, mq[0][DATA_W-1:0]);
      check("out_flags", out_flags, mq[0][DATA_W+2:DATA_W]);
    end
    if (srst) model_reset();
    else begin
      pop = (mq.size() != 0) && out_ready;
      acc = mul_valid && ((mq.size() < DEPTH) || pop);
      pf  = acc ? m_flag : 3'b000;
      if (pop) void'(mq.pop_front());
      if (acc) begin
        mq.push_back({m_flag, mul_result});
        m_rcnt = m_rcnt + 1;
      end
      if (mul_valid && !acc) m_drop = 1;
`ifdef COLLECT_STICKY_FLAGS_EN
      m_sticky = clr_sticky ? pf : (m_sticky | pf);
`else
      m_sticky = pf & 3'b000;
`endif
      if (mul_enable) m_flag = {mul_exc, mul_ovf, mul_unf};
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle(); srst = 1; step(); idle();
  endtask

  initial begin
    logic prev_en;
    idle(); srst = 1;
    @(posedge clk); #1;
    model_reset();
    step();
    idle(); step();
    check("rst_count", count, 0);
    check("rst_issue_ready", issue_ready, 1);
    check("rst_out_valid", out_valid, 0);

    // Overflow-flagged result travels through with its flags.
    mul_enable = 1; mul_ovf = 1; step();
    idle(); mul_valid = 1; mul_result = 64'h7FF0000000000000; step();
    idle(); step();
    check("r033_valid", out_valid, 1);
    check("r033_data", out_data, 64'h7FF0000000000000);
    check("r033_flags", out_flags, 3'b010);
    out_ready = 1; step(); idle();

    // Fill to DEPTH with consumer stalled, then overflow with and without a pop.
    do_reset();
    for (int i = 0; i <= 4; i++) begin
      idle();
      mul_enable = (i < 4);
      mul_valid  = (i > 0);
      mul_result = 64'(100 + i);
      mul_unf    = i[0];
      step();
    end
    idle();
    check("r034_count", count, 4);
    check("r034_issue_ready", issue_ready, 0);
    check("r034_drop", drop_err, 0);
    mul_valid = 1; mul_result = 64'hDEAD; step();
    check("r035_drop", drop_err, 1);
    check("r035_count", count, 4);
    check("r035_rcnt", result_cnt, 4);
    mul_valid = 1; mul_result = 64'hBEEF; out_ready = 1; step();
    check("r035_count_pop", count, 4);
    check("r035_rcnt_pop", result_cnt, 5);
    idle(); out_ready = 1;
    for (int i = 0; i < 4; i++) step();

    // Ten results with a toggling consumer; pointers wrap more than once.
    do_reset();
    for (int i = 0; i < 24; i++) begin
      idle();
      mul_valid  = (i < 20) && !i[0];
      mul_result = 64'(32'h1000 + i);
      out_ready  = i[1];
      step();
    end
    idle(); out_ready = 1;
    for (int i = 0; i < 6; i++) step();
    check("r036_rcnt", result_cnt, 10);
    check("r036_empty", out_valid, 0);

    // Reset with occupancy and an in-flight result.
    idle();
    mul_valid = 1; mul_result = 64'h11; step();
    mul_valid = 1; mul_result = 64'h22; step();
    srst = 1; mul_valid = 1; mul_result = 64'h33; step();
    idle();
    check("r037_count", count, 0);
    check("r037_valid", out_valid, 0);
    check("r037_rcnt", result_cnt, 0);
    check("r037_drop", drop_err, 0);

`ifdef COLLECT_STICKY_FLAGS_EN
    do_reset();
    mul_enable = 1; mul_exc = 1; step();
    idle(); mul_valid = 1; mul_enable = 1; mul_unf = 1; step();
    idle(); mul_valid = 1; step();
    idle(); step();
    check("r038_set", sticky_flags, 3'b101);
    mul_enable = 1; mul_ovf = 1; step();
    idle(); mul_valid = 1; clr_sticky = 1; step();
    idle(); step();
    check("r038_clr", sticky_flags, 3'b010);
`endif

    // Random traffic with realistic enable-to-valid timing.
    do_reset();
    prev_en = 0;
    for (int i = 0; i < 400; i++) begin
      idle();
      mul_valid  = prev_en;
      mul_result = {$urandom, $urandom};
      mul_enable = ($urandom_range(0, 1) == 1);
      mul_exc    = $urandom_range(0, 1) == 1;
      mul_ovf    = $urandom_range(0, 1) == 1;
      mul_unf    = $urandom_range(0, 1) == 1;
      out_ready  = ($urandom_range(0, 2) != 0);
      clr_sticky = ($urandom_range(0, 9) == 0);
      srst       = ($urandom_range(0, 59) == 0);
      prev_en    = mul_enable && !srst;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mul_result_collector.md
MUL_RESULT_COLLECTOR -- requirements
Module: mul_result_collector

Interface
REQ-001 SHALL have parameter DATA_W, default 64, meaning result word width.
REQ-002 SHALL have parameter DEPTH, default 4, meaning FIFO entries; power of two, >= 2.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port srst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port mul_enable  input  1  enable driven to the multiplier this cycle.
REQ-006 SHALL have port mul_exc, mul_ovf, mul_unf  input  1 each  multiplier flags, valid in the mul_enable cycle.
REQ-007 SHALL have port mul_valid  input  1  multiplier result valid, one cycle after mul_enable.
REQ-008 SHALL have port mul_result  input  DATA_W  multiplier registered result.
REQ-009 SHALL have port issue_ready  output  1  the issuer may assert mul_enable this cycle.
REQ-010 SHALL have port out_valid  output  1  FIFO head valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts head.
REQ-012 SHALL have port out_data  output  DATA_W  head result.
REQ-013 SHALL have port out_flags  output  3  head flags {exc,ovf,unf}.
REQ-014 SHALL have port count  output  clog2(DEPTH)+1  current occupancy.
REQ-015 SHALL have port drop_err  output  1  sticky: a result was lost.
REQ-016 SHALL have port result_cnt  output  32  total pushed results, wraps modulo 2^32.
REQ-017 SHALL have ports sticky_flags  output  3 and clr_sticky  input  1, per REQ-031/032.

Function
REQ-018 SHALL register {mul_exc,mul_ovf,mul_unf} into flag_d whenever mul_enable=1, holding otherwise, so flags align with mul_valid.
REQ-019 SHALL push {flag_d, mul_result} when mul_valid=1 and (count<DEPTH or pop occurs the same cycle).
REQ-020 SHALL pop when out_valid=1 and out_ready=1; out_valid = (count!=0); out_data/out_flags show the head entry combinationally from storage.
REQ-021 SHALL, on mul_valid=1 with count=DEPTH and no pop, discard the result, set drop_err=1, leave count and result_cnt unchanged.
REQ-022 SHALL drive issue_ready = ((count + mul_valid) < DEPTH), ignoring any pop in the same cycle (conservative).
REQ-023 SHALL, on simultaneous push and pop, keep count unchanged and advance both pointers.
REQ-024 SHALL use clog2(DEPTH)-bit read/write pointers wrapping from DEPTH-1 to 0.
REQ-025 SHALL increment result_cnt by 1 on every accepted push; 0xFFFFFFFF+1 -> 0.
REQ-026 SHALL hold drop_err at 1 until srst.
REQ-027 SHALL make a pushed entry visible at out_valid one cycle after the push edge (push-to-out latency 1).

Reset
REQ-028 SHALL, when srst=1 at a rising edge, clear count, pointers, flag_d, drop_err, result_cnt, sticky_flags to 0; out_valid=0, issue_ready=1 next cycle.
REQ-029 SHALL, with srst=1, ignore mul_valid and pop in that cycle; an in-flight result is lost without setting drop_err.
REQ-030 SHALL leave storage contents unreset; out_data is don't-care while out_valid=0.

Configuration
REQ-031 SHALL, with COLLECT_STICKY_FLAGS_EN defined, OR the flags of every accepted push into sticky_flags; clr_sticky=1 clears to 0, except that a push in that same cycle sets its flags (set wins).
REQ-032 SHALL, without COLLECT_STICKY_FLAGS_EN, tie sticky_flags to 0 and ignore clr_sticky; all other behaviour identical.

Verification
REQ-033 SHALL cover: mul_enable with mul_ovf=1, mul_valid next cycle, result 0x7FF0000000000000 -> out_valid next cycle, out_data=0x7FF0000000000000, out_flags=3'b010.
REQ-034 SHALL cover: out_ready=0, 4 back-to-back results -> count=4, issue_ready=0 from the cycle count reaches 3 with mul_valid=1; drop_err=0.
REQ-035 SHALL cover: count=4, mul_valid=1, out_ready=0 -> drop_err=1, count stays 4, result_cnt stays 4; same with out_ready=1 -> push accepted, count 4.
REQ-036 SHALL cover: 10 results through DEPTH=4 with out_ready toggling -> in-order output, pointer wrap, result_cnt=10.
REQ-037 SHALL cover: srst asserted with count=2 and mul_valid=1 -> count=0, out_valid=0, result_cnt=0, drop_err=0 next cycle.
REQ-038 SHALL cover, with COLLECT_STICKY_FLAGS_EN: results with exc then unf -> sticky_flags=3'b101; clr_sticky with a simultaneous ovf push -> 3'b010.
